dmem_arbiter: RTL and testbench
===============================

# dmem_arbiter

Two-port arbiter that shares the single 512-word data memory between the RISC-V core's load/store port and a DMA/debug port. Fixed core priority with a bounded-starvation counter for the DMA port. Registered memory-side command outputs. Read responses routed back to the issuing requester via a small owner pipeline. Sits between the core datapath (`wr`/`rd`/`addr`/`wr_data`/`rd_data`) and the data memory instance.

## Interface
- `ADDR_W`, default 9: word address width; matches the data memory depth.
- `DATA_W`, default 32: data width.
- `MAX_WAIT`, default 4: consecutive cycles the DMA may lose arbitration while requesting; legal range 1..15.

- `clk` in 1: single clock; all state updates on its rising edge.
- `reset` in 1: asynchronous, active-low reset.
- `core_req` in 1: core access request; held with its fields until `core_gnt`.
- `core_we` in 1: 1 = write, 0 = read.
- `core_addr` in ADDR_W: core word address.
- `core_wdata` in DATA_W: core write data.
- `core_gnt` out 1: combinational; the core access is accepted this cycle.
- `core_stall` out 1: `core_req & ~core_gnt`; freezes the core pipeline.
- `core_rvalid` out 1: core read data valid this cycle.
- `core_rdata` out DATA_W: core read data, meaningful only while `core_rvalid` is high.
- `dma_req`, `dma_we`, `dma_addr`, `dma_wdata`, `dma_gnt`, `dma_rvalid`, `dma_rdata`: same semantics as the core port, for the DMA requester.
- `mem_wr` out 1: registered memory write strobe.
- `mem_rd` out 1: registered memory read strobe.
- `mem_addr` out ADDR_W: registered memory address.
- `mem_wr_data` out DATA_W: registered memory write data.
- `mem_rd_data` in DATA_W: memory read data; valid one cycle after `mem_rd`.

## Operation
- At most one grant per cycle. `core_gnt` and `dma_gnt` are never high together.
- Arbitration:
  - Only one port requesting: that port is granted.
  - Both requesting and `wait_cnt < MAX_WAIT`: core wins.
  - Both requesting and `wait_cnt == MAX_WAIT`: DMA wins.
- `wait_cnt` (4-bit):
  - Increments when `dma_req & ~dma_gnt`.
  - Clears to 0 when `dma_gnt` is high or `dma_req` is low.
  - Saturates at `MAX_WAIT`.
- Issue stage, on grant:
  - Register `mem_addr`, `mem_wr_data`, `mem_wr = we`, `mem_rd = ~we` from the winner.
  - With no grant, `mem_wr = mem_rd = 0`; `mem_addr` and `mem_wr_data` hold.
  - `mem_wr` and `mem_rd` are mutually exclusive in every cycle.
- Owner pipeline: 2-stage shift of {valid, owner}.
  - Stage 1 is loaded on a read grant.
  - Stage 2 drives `*_rvalid`.
  - `core_rdata` and `dma_rdata` both pass `mem_rd_data` directly; only the `rvalid` of the stage-2 owner is high.
- Fully pipelined: a new grant every cycle is allowed, and reads and writes may interleave back-to-back.
- Writes produce no response.

## Timing
- Cycle N: request high with `gnt` high (combinational).
- Cycle N+1: `mem_rd` or `mem_wr` high, with `mem_addr` and `mem_wr_data` from cycle N.
- Cycle N+2, reads only: `<owner>_rvalid` high and `<owner>_rdata = mem_rd_data`.
- Read latency is 2 cycles from grant; write latency to memory is 1 cycle.
- Reset values while `reset` is low:
  - `mem_wr = mem_rd = 0`, `mem_addr = 0`, `mem_wr_data = 0`.
  - `core_rvalid = dma_rvalid = 0`.
  - `core_gnt = dma_gnt = 0`, so `core_stall = core_req`.
  - `wait_cnt = 0` and owner pipeline empty.
- Reset mid-operation: in-flight reads are discarded. No `rvalid` is produced after reset release for grants made before reset.
- First cycle after reset release: arbitration is normal.
- A requester dropping `req` without a grant is legal; no state changes except `wait_cnt` clearing.

## Test plan
- Reset: drive `reset = 0` with both `req` = 1 → all `mem_*`, `gnt` and `rvalid` = 0, and `core_stall = 1`. After release, `core_gnt = 1` in the first cycle.
- Core read, addr 5, memory holds `0xDEADBEEF`, grant at cycle N → `mem_rd = 1` with `mem_addr = 5` at N+1; `core_rvalid = 1` and `core_rdata = 0xDEADBEEF` at N+2; `dma_rvalid = 0` throughout.
- DMA write, addr 300, data `0x12345678`, core idle → `dma_gnt` at N; `mem_wr = 1`, `mem_addr = 300`, `mem_wr_data = 0x12345678` at N+1; `mem_rd = 0`; no `rvalid`.
- Contention, `MAX_WAIT = 4`, both requesting continuously for 15 cycles → grant sequence C,C,C,C,D repeated 3 times. `core_stall` is high exactly on the D cycles.
- Back-to-back reads core@1, DMA@2, core@3 on consecutive grant cycles, memory = addr+100 → `core_rvalid` (101), `dma_rvalid` (102), `core_rvalid` (103) on three consecutive cycles, correctly routed.
- Reset asserted the cycle after a core read grant, released 2 cycles later → no `core_rvalid` ever appears for that read.

Source files
------------

// File: rtl/dmem_arbiter.sv
// dmem_arbiter
//   Shares the single data memory between the core load/store port and a
//   DMA/debug port. The core has fixed priority; the DMA port is guaranteed a
//   grant after MAX_WAIT consecutive lost arbitrations. Memory-side commands
//   are registered, and read responses are steered back to the issuing port
//   through a two-stage {valid, owner} pipeline.
//
// Ports
//   clk, reset        : clock, asynchronous active-low reset
//   core_req/we/addr/wdata -> core_gnt, core_stall, core_rvalid, core_rdata
//   dma_req/we/addr/wdata  -> dma_gnt, dma_rvalid, dma_rdata
//   mem_wr, mem_rd, mem_addr, mem_wr_data : registered memory command
//   mem_rd_data       : memory read data, valid one cycle after mem_rd
module dmem_arbiter #(
  parameter int unsigned ADDR_W   = 9,
  parameter int unsigned DATA_W   = 32,
  parameter int unsigned MAX_WAIT = 4
) (
  input  logic              clk,
  input  logic              reset,

  input  logic              core_req,
  input  logic              core_we,
  input  logic [ADDR_W-1:0] core_addr,
  input  logic [DATA_W-1:0] core_wdata,
  output logic              core_gnt,
  output logic              core_stall,
  output logic              core_rvalid,
  output logic [DATA_W-1:0] core_rdata,

  input  logic              dma_req,
  input  logic              dma_we,
  input  logic [ADDR_W-1:0] dma_addr,
  input  logic [DATA_W-1:0] dma_wdata,
  output logic              dma_gnt,
  output logic              dma_rvalid,
  output logic [DATA_W-1:0] dma_rdata,

  output logic              mem_wr,
  output logic              mem_rd,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wr_data,
  input  logic [DATA_W-1:0] mem_rd_data
);

  typedef enum logic {
    OWN_CORE = 1'b0,
    OWN_DMA  = 1'b1
  } owner_e;

  localparam logic [3:0] LP_MAX_WAIT = 4'(MAX_WAIT);

  // Arbitration
  logic              w_core_gnt;
  logic              w_dma_gnt;
  logic              w_dma_prio;
  logic              w_any_gnt;
  logic              w_gnt_we;
  logic [ADDR_W-1:0] w_gnt_addr;
  logic [DATA_W-1:0] w_gnt_wdata;
  owner_e            w_gnt_owner;

  logic [3:0]        r_wait_cnt;

  // Issue registers
  logic              r_mem_wr;
  logic              r_mem_rd;
  logic [ADDR_W-1:0] r_mem_addr;
  logic [DATA_W-1:0] r_mem_wr_data;

  // Owner pipeline
  logic              r_s1_valid;
  owner_e            r_s1_owner;
  logic              r_s2_valid;
  owner_e            r_s2_owner;

  assign w_dma_prio = (r_wait_cnt == LP_MAX_WAIT);

  // Grants are combinational but forced low while reset is held, so the
  // stall output mirrors the request during reset.
  always_comb begin
    w_core_gnt = 1'b0;
    w_dma_gnt  = 1'b0;
    if (reset) begin
      if (core_req && !(dma_req && w_dma_prio)) begin
        w_core_gnt = 1'b1;
      end else if (dma_req) begin
        w_dma_gnt = 1'b1;
      end
    end
  end

  always_comb begin
    w_any_gnt   = w_core_gnt | w_dma_gnt;
    w_gnt_we    = core_we;
    w_gnt_addr  = core_addr;
    w_gnt_wdata = core_wdata;
    w_gnt_owner = OWN_CORE;
    if (w_dma_gnt) begin
      w_gnt_we    = dma_we;
      w_gnt_addr  = dma_addr;
      w_gnt_wdata = dma_wdata;
      w_gnt_owner = OWN_DMA;
    end
  end

  // Starvation counter: counts consecutive lost cycles while DMA requests.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_wait_cnt <= '0;
    end else if (dma_req && !w_dma_gnt) begin
      if (r_wait_cnt != LP_MAX_WAIT) begin
        r_wait_cnt <= r_wait_cnt + 4'd1;
      end
    end else begin
      r_wait_cnt <= '0;
    end
  end

  // Issue stage: address/data hold when idle, strobes drop.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_mem_wr      <= 1'b0;
      r_mem_rd      <= 1'b0;
      r_mem_addr    <= '0;
      r_mem_wr_data <= '0;
    end else begin
      r_mem_wr <= w_any_gnt & w_gnt_we;
      r_mem_rd <= w_any_gnt & ~w_gnt_we;
      if (w_any_gnt) begin
        r_mem_addr    <= w_gnt_addr;
        r_mem_wr_data <= w_gnt_wdata;
      end
    end
  end

  // Stage 1 aligns with mem_rd, stage 2 with the returning mem_rd_data.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_s1_valid <= 1'b0;
      r_s1_owner <= OWN_CORE;
      r_s2_valid <= 1'b0;
      r_s2_owner <= OWN_CORE;
    end else begin
      r_s1_valid <= w_any_gnt & ~w_gnt_we;
      r_s1_owner <= w_gnt_owner;
      r_s2_valid <= r_s1_valid;
      r_s2_owner <= r_s1_owner;
    end
  end

  assign core_gnt    = w_core_gnt;
  assign dma_gnt     = w_dma_gnt;
  assign core_stall  = core_req & ~w_core_gnt;

  assign mem_wr      = r_mem_wr;
  assign mem_rd      = r_mem_rd;
  assign mem_addr    = r_mem_addr;
  assign mem_wr_data = r_mem_wr_data;

  assign core_rvalid = r_s2_valid & (r_s2_owner == OWN_CORE);
  assign dma_rvalid  = r_s2_valid & (r_s2_owner == OWN_DMA);
  assign core_rdata  = mem_rd_data;
  assign dma_rdata   = mem_rd_data;

endmodule

// File: tb/tb_dmem_arbiter.sv
module tb_dmem_arbiter;

  localparam int unsigned ADDR_W = 9;
  localparam int unsigned DATA_W = 32;

  logic              clk;
  logic              reset;
  logic              core_req, core_we;
  logic [ADDR_W-1:0] core_addr;
  logic [DATA_W-1:0] core_wdata;
  logic              core_gnt, core_stall, core_rvalid;
  logic [DATA_W-1:0] core_rdata;
  logic              dma_req, dma_we;
  logic [ADDR_W-1:0] dma_addr;
  logic [DATA_W-1:0] dma_wdata;
  logic              dma_gnt, dma_rvalid;
  logic [DATA_W-1:0] dma_rdata;
  logic              mem_wr, mem_rd;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wr_data;
  logic [DATA_W-1:0] mem_rd_data;

  logic [DATA_W-1:0] mem [0:511];

  int checks   = 0;
  int failures = 0;

  dmem_arbiter #(
    .ADDR_W  (9),
    .DATA_W  (32),
    .MAX_WAIT(4)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .core_req   (core_req),
    .core_we    (core_we),
    .core_addr  (core_addr),
    .core_wdata (core_wdata),
    .core_gnt   (core_gnt),
    .core_stall (core_stall),
    .core_rvalid(core_rvalid),
    .core_rdata (core_rdata),
    .dma_req    (dma_req),
    .dma_we     (dma_we),
    .dma_addr   (dma_addr),
    .dma_wdata  (dma_wdata),
    .dma_gnt    (dma_gnt),
    .dma_rvalid (dma_rvalid),
    .dma_rdata  (dma_rdata),
    .mem_wr     (mem_wr),
    .mem_rd     (mem_rd),
    .mem_addr   (mem_addr),
    .mem_wr_data(mem_wr_data),
    .mem_rd_data(mem_rd_data)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Read-only memory model: one-cycle read latency.
  always @(posedge clk) begin
    if (mem_rd) mem_rd_data <= mem[mem_addr];
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Advance to just after a rising edge; inputs are driven here.
  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  initial begin
    for (int i = 0; i < 512; i++) mem[i] = DATA_W'(i + 100);
    mem[5] = 32'hDEADBEEF;
    mem_rd_data = '0;

    // Reset with both requesting
    reset = 1'b0;
    core_req = 1'b1; core_we = 1'b0; core_addr = '0; core_wdata = '0;
    dma_req  = 1'b1; dma_we  = 1'b0; dma_addr  = '0; dma_wdata  = '0;
    tick(); tick();
    #1;
    check("rst_mem_wr",      64'(mem_wr), 64'd0);
    check("rst_mem_rd",      64'(mem_rd), 64'd0);
    check("rst_mem_addr",    64'(mem_addr), 64'd0);
    check("rst_mem_wr_data", 64'(mem_wr_data), 64'd0);
    check("rst_core_gnt",    64'(core_gnt), 64'd0);
    check("rst_dma_gnt",     64'(dma_gnt), 64'd0);
    check("rst_core_rvalid", 64'(core_rvalid), 64'd0);
    check("rst_dma_rvalid",  64'(dma_rvalid), 64'd0);
    check("rst_core_stall",  64'(core_stall), 64'd1);

    // Release: first cycle arbitrates normally
    tick();
    reset = 1'b1;
    #1;
    check("rel_core_gnt", 64'(core_gnt), 64'd1);
    check("rel_dma_gnt",  64'(dma_gnt), 64'd0);

    // Idle so wait count clears
    tick();
    core_req = 1'b0; dma_req = 1'b0;
    tick(); tick(); tick();

    // Core read of addr 5
    core_req = 1'b1; core_we = 1'b0; core_addr = 9'd5;
    #1;
    check("cr_core_gnt", 64'(core_gnt), 64'd1);
    check("cr_dma_gnt",  64'(dma_gnt), 64'd0);
    tick();
    core_req = 1'b0;
    #1;
    check("cr_mem_rd",      64'(mem_rd), 64'd1);
    check("cr_mem_wr",      64'(mem_wr), 64'd0);
    check("cr_mem_addr",    64'(mem_addr), 64'd5);
    check("cr_rvalid_n1",   64'(core_rvalid), 64'd0);
    check("cr_dma_rv_n1",   64'(dma_rvalid), 64'd0);
    tick();
    #1;
    check("cr_core_rvalid", 64'(core_rvalid), 64'd1);
    check("cr_core_rdata",  64'(core_rdata), 64'hDEADBEEF);
    check("cr_dma_rv_n2",   64'(dma_rvalid), 64'd0);
    check("cr_mem_rd_idle", 64'(mem_rd), 64'd0);
    tick();
    #1;
    check("cr_core_rv_n3",  64'(core_rvalid), 64'd0);

    // DMA write to addr 300
    tick();
    dma_req = 1'b1; dma_we = 1'b1; dma_addr = 9'd300; dma_wdata = 32'h12345678;
    #1;
    check("dw_dma_gnt",  64'(dma_gnt), 64'd1);
    check("dw_core_gnt", 64'(core_gnt), 64'd0);
    tick();
    dma_req = 1'b0;
    #1;
    check("dw_mem_wr",      64'(mem_wr), 64'd1);
    check("dw_mem_rd",      64'(mem_rd), 64'd0);
    check("dw_mem_addr",    64'(mem_addr), 64'd300);
    check("dw_mem_wr_data", 64'(mem_wr_data), 64'h12345678);
    tick();
    #1;
    check("dw_dma_rvalid",  64'(dma_rvalid), 64'd0);
    check("dw_core_rvalid", 64'(core_rvalid), 64'd0);
    check("dw_mem_wr_idle", 64'(mem_wr), 64'd0);
    check("dw_addr_hold",   64'(mem_addr), 64'd300);

    // Contention: C,C,C,C,D x3
    tick(); tick();
    core_req = 1'b1; core_we = 1'b1; core_addr = 9'd10; core_wdata = 32'h0;
    dma_req  = 1'b1; dma_we  = 1'b1; dma_addr  = 9'd20; dma_wdata  = 32'h0;
    for (int i = 0; i < 15; i++) begin
      logic exp_d;
      exp_d = ((i % 5) == 4);
      #1;
      check($sformatf("ct_core_gnt_%0d", i), 64'(core_gnt), 64'(!exp_d));
      check($sformatf("ct_dma_gnt_%0d", i),  64'(dma_gnt),  64'(exp_d));
      check($sformatf("ct_stall_%0d", i),    64'(core_stall), 64'(exp_d));
      tick();
    end
    core_req = 1'b0; dma_req = 1'b0;
    core_we = 1'b0; dma_we = 1'b0;
    tick(); tick();

    // Back-to-back reads: core@1, dma@2, core@3
    core_req = 1'b1; core_addr = 9'd1;
    #1;
    check("bb_g1_core", 64'(core_gnt), 64'd1);
    tick();
    core_req = 1'b0;
    dma_req = 1'b1; dma_addr = 9'd2;
    #1;
    check("bb_g2_dma", 64'(dma_gnt), 64'd1);
    tick();
    dma_req = 1'b0;
    core_req = 1'b1; core_addr = 9'd3;
    #1;
    check("bb_g3_core",    64'(core_gnt), 64'd1);
    check("bb_r1_core_rv", 64'(core_rvalid), 64'd1);
    check("bb_r1_dma_rv",  64'(dma_rvalid), 64'd0);
    check("bb_r1_data",    64'(core_rdata), 64'd101);
    tick();
    core_req = 1'b0;
    #1;
    check("bb_r2_dma_rv",  64'(dma_rvalid), 64'd1);
    check("bb_r2_core_rv", 64'(core_rvalid), 64'd0);
    check("bb_r2_data",    64'(dma_rdata), 64'd102);
    tick();
    #1;
    check("bb_r3_core_rv", 64'(core_rvalid), 64'd1);
    check("bb_r3_dma_rv",  64'(dma_rvalid), 64'd0);
    check("bb_r3_data",    64'(core_rdata), 64'd103);
    tick(); tick();

    // Reset one cycle after a core read grant
    core_req = 1'b1; core_addr = 9'd5;
    #1;
    check("rm_core_gnt", 64'(core_gnt), 64'd1);
    tick();
    core_req = 1'b0;
    reset = 1'b0;
    #1;
    check("rm_mem_rd_cleared", 64'(mem_rd), 64'd0);
    check("rm_rvalid_0",       64'(core_rvalid), 64'd0);
    tick();
    #1;
    check("rm_rvalid_1",       64'(core_rvalid), 64'd0);
    tick();
    reset = 1'b1;
    for (int i = 0; i < 4; i++) begin
      #1;
      check($sformatf("rm_post_core_rv_%0d", i), 64'(core_rvalid), 64'd0);
      check($sformatf("rm_post_dma_rv_%0d", i),  64'(dma_rvalid), 64'd0);
      tick();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
